window_line_buffer: RTL and testbench
=====================================

# window_line_buffer

Streaming 3x3 window generator that sits directly upstream of the convolution accelerator. Accepts a raster-scan pixel stream with valid/ready handshake and buffers two previous image lines. Emits one complete 3x3 window per interior pixel, with window elements numbered in the same order as the accelerator's window/kernel register indices 0..8. Valid-region only, no padding: a WxH frame yields (W-2)*(H-2) windows.

## Interface
Parameters:
- DATA_W, 32: pixel width in bits; signed two's complement, passed through unmodified.
- IMG_W_MAX, 64: maximum line width; sets line-buffer depth.
- CW, $clog2(IMG_W_MAX)+1: width of cfg_width.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse; latches configuration and begins a frame.
- cfg_width  in  CW  line width W; legal range 3..IMG_W_MAX.
- cfg_height  in  16  frame height H; legal range >=3.
- in_valid  in  1  pixel available.
- in_data  in  DATA_W  pixel value.
- in_ready  out  1  block accepts the pixel this cycle.
- win_valid  out  1  window available.
- win_data  out  9*DATA_W  element k occupies bits [k*DATA_W +: DATA_W].
- win_ready  in  1  consumer accepts the window.
- win_x  out  16  column of the window's centre.
- win_y  out  16  row of the window's centre.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse when the frame completes.
- cfg_err  out  1  last start carried an illegal configuration.

## Operation
- FSM has three states: IDLE, RUN, DONE.
- IDLE -> RUN: on start with legal cfg_width/cfg_height. Latch W and H, clear col/row, clear cfg_err.
- IDLE, illegal start: stay in IDLE and set cfg_err=1, held until the next start.
- start outside IDLE is ignored.
- Pixel accept: a pixel is accepted when in_valid && in_ready.
- in_ready = (state==RUN) && !pix_done && (!win_valid || win_ready).
- Column/row counters: col increments on each accept; at col==W-1 it wraps to 0 and row increments.
- Line buffers:
  - lb1[col] holds row y-1 and lb0[col] holds row y-2.
  - On accept: lb0[col] <= lb1[col] and lb1[col] <= in_data.
  - Reads are combinational at address col.
- Column shift: the three-column shift register shifts in {lb0[col], lb1[col], in_data} on every accept. It clears at col==0.
- Window element order: element k = row r, column c of the window, with k = 3r+c.
  - Element 0 is pixel (x-2, y-2).
  - Element 8 is the current pixel (x, y).
- Window emission: when a pixel is accepted at (x, y) with x>=2 and y>=2, the output register loads win_data, sets win_x=x-1 and win_y=y-1, and sets win_valid.
- Window retirement: win_valid clears on win_ready unless a new window loads in the same cycle.
- pix_done: sets when pixel (W-1, H-1) is accepted.
- RUN -> DONE: once pix_done is set and win_valid==0.
- DONE: frame_done=1 for one cycle, then IDLE.
- Extra in_valid after the last pixel stays unaccepted.

## Timing
- Reset values: in_ready=0, win_valid=0, win_data=0, win_x=0, win_y=0, busy=0, frame_done=0, cfg_err=0. State is IDLE; counters are 0.
- Line-buffer contents are not reset; the y>=2 gating makes them don't-care.
- Latency:
  - start edge -> in_ready high on the next cycle.
  - Accepted pixel -> its window is valid on the next cycle.
- Throughput: one pixel per cycle while win_ready is held high.
- Backpressure: while win_valid && !win_ready, in_ready=0 and win_data/win_x/win_y are held stable.
- Simultaneous accept and drain: win_ready with a new accept in the same cycle drains the old window and loads the new one; win_valid stays 1.
- busy = (state != IDLE).
- frame_done fires 1 cycle after the last window handshake. If the last pixel yields no pending window, it fires 1 cycle after pix_done.
- Reset mid-frame: returns to IDLE immediately and drops any pending window. The next frame is unaffected.

## Configuration
- WLB_WIN_COUNT_EN defined:
  - Adds output win_count, 16 bits: number of windows handshaken this frame.
  - Cleared on a legal start; holds its value after frame_done.
  - Reset value 0.
- Undefined: the port and the counter are absent; all other behaviour is identical.

## Structure
- wlb_pkg: state enum (IDLE/RUN/DONE), window element index constants WIN_TL=0 .. WIN_BR=8, legality limits MIN_DIM=3.
- Sub-module wlb_line_ram: one IMG_W_MAX x DATA_W buffer with combinational read and synchronous write. Instantiated twice (lb0, lb1).

## Test plan
- 4x4 frame, pixels 1..16, win_ready=1:
  - exactly 4 windows.
  - first window {1,2,3,5,6,7,9,10,11} at (1,1).
  - last window {6,7,8,10,11,12,14,15,16} at (2,2).
  - frame_done one cycle after the 4th handshake.
- Same frame, win_ready low for 5 cycles after the first window: in_ready=0 throughout, window held unchanged, final output identical.
- start with cfg_width=2 -> cfg_err=1, busy=0, in_ready never asserts. A following legal start clears cfg_err.
- rst asserted mid-frame, then a 3x3 frame of pixels -5..3 -> exactly one window {-5,...,3} at (1,1).
- Back-to-back frames, 5x3 then 3x5 -> 3 windows each, no cross-frame mixing, win_count=3 after each (macro defined).

Source files
------------

// File: rtl/wlb_pkg.sv
// wlb_pkg: shared definitions for the 3x3 window line buffer.
//   wlb_state_t    : frame control states (IDLE / RUN / DONE)
//   WIN_TL..WIN_BR : window element indices, k = 3*row + col, matching the
//                    accelerator's window/kernel register numbering
//   MIN_DIM        : smallest legal frame width/height
package wlb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } wlb_state_t;

    localparam int unsigned WIN_TL = 0;
    localparam int unsigned WIN_TC = 1;
    localparam int unsigned WIN_TR = 2;
    localparam int unsigned WIN_ML = 3;
    localparam int unsigned WIN_MC = 4;
    localparam int unsigned WIN_MR = 5;
    localparam int unsigned WIN_BL = 6;
    localparam int unsigned WIN_BC = 7;
    localparam int unsigned WIN_BR = 8;

    localparam int unsigned MIN_DIM = 3;

endpackage

// File: rtl/wlb_line_ram.sv
// wlb_line_ram: one image line of storage, DEPTH x DATA_W.
//   clk   : write clock (rising edge)
//   we    : write enable
//   addr  : shared read/write address
//   wdata : write data
//   rdata : combinational read of mem[addr] (pre-write value)
// Contents are not reset.
module wlb_line_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/window_line_buffer.sv
// window_line_buffer: streaming 3x3 valid-region window generator.
// Takes a raster-scan pixel stream, keeps the two previous lines in line
// RAMs and emits one 3x3 window per interior pixel ((W-2)*(H-2) per frame).
//   clk, rst            : clock, asynchronous active-high reset
//   start               : one-cycle pulse, latches cfg_width/cfg_height
//   cfg_width/height    : frame geometry (W in 3..IMG_W_MAX, H >= 3)
//   in_valid/in_data/in_ready    : pixel input handshake
//   win_valid/win_data/win_ready : window output handshake, element k at
//                                  win_data[k*DATA_W +: DATA_W]
//   win_x, win_y        : centre coordinate of the emitted window
//   busy                : frame in progress
//   frame_done          : one-cycle pulse at end of frame
//   cfg_err             : last start carried an illegal configuration
// Optional: define WLB_WIN_COUNT_EN to add win_count (windows handshaken
// in the current frame).
module window_line_buffer
    import wlb_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int IMG_W_MAX = 64,
    parameter int CW        = $clog2(IMG_W_MAX) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CW-1:0]       cfg_width,
    input  logic [15:0]         cfg_height,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   in_data,
    output logic                in_ready,
    output logic                win_valid,
    output logic [9*DATA_W-1:0] win_data,
    input  logic                win_ready,
    output logic [15:0]         win_x,
    output logic [15:0]         win_y,
    output logic                busy,
    output logic                frame_done,
    output logic                cfg_err
`ifdef WLB_WIN_COUNT_EN
    ,
    output logic [15:0]         win_count
`endif
);

    localparam int AW = $clog2(IMG_W_MAX);

    wlb_state_t        state;
    logic [CW-1:0]     w_reg;
    logic [15:0]       h_reg;
    logic [CW-1:0]     col;
    logic [15:0]       row;
    logic              pix_done;

    logic [DATA_W-1:0] lb0_rd;
    logic [DATA_W-1:0] lb1_rd;

    // Two previous columns of the window: c0 = x-2, c1 = x-1.
    // _t = row y-2, _m = row y-1, _b = row y.
    logic [DATA_W-1:0] c0_t, c0_m, c0_b;
    logic [DATA_W-1:0] c1_t, c1_m, c1_b;

    logic              accept;
    logic              load;
    logic              handshake;
    logic              cfg_legal;
    logic              last_col;
    logic [9*DATA_W-1:0] win_next;

    assign busy      = (state != IDLE);
    assign in_ready  = (state == RUN) && !pix_done && (!win_valid || win_ready);
    assign accept    = in_valid && in_ready;
    assign handshake = win_valid && win_ready;
    assign last_col  = (col == w_reg - CW'(1));
    assign load      = accept && (col >= CW'(2)) && (row >= 16'd2);
    assign cfg_legal = (cfg_width >= CW'(MIN_DIM)) && (cfg_width <= CW'(IMG_W_MAX))
                    && (cfg_height >= 16'(MIN_DIM));

    wlb_line_ram #(.DATA_W(DATA_W), .DEPTH(IMG_W_MAX)) u_lb0 (
        .clk   (clk),
        .we    (accept),
        .addr  (col[AW-1:0]),
        .wdata (lb1_rd),
        .rdata (lb0_rd)
    );

    wlb_line_ram #(.DATA_W(DATA_W), .DEPTH(IMG_W_MAX)) u_lb1 (
        .clk   (clk),
        .we    (accept),
        .addr  (col[AW-1:0]),
        .wdata (in_data),
        .rdata (lb1_rd)
    );

    always_comb begin
        win_next = '0;
        win_next[WIN_TL*DATA_W +: DATA_W] = c0_t;
        win_next[WIN_TC*DATA_W +: DATA_W] = c1_t;
        win_next[WIN_TR*DATA_W +: DATA_W] = lb0_rd;
        win_next[WIN_ML*DATA_W +: DATA_W] = c0_m;
        win_next[WIN_MC*DATA_W +: DATA_W] = c1_m;
        win_next[WIN_MR*DATA_W +: DATA_W] = lb1_rd;
        win_next[WIN_BL*DATA_W +: DATA_W] = c0_b;
        win_next[WIN_BC*DATA_W +: DATA_W] = c1_b;
        win_next[WIN_BR*DATA_W +: DATA_W] = in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            w_reg      <= '0;
            h_reg      <= '0;
            col        <= '0;
            row        <= '0;
            pix_done   <= 1'b0;
            c0_t       <= '0;
            c0_m       <= '0;
            c0_b       <= '0;
            c1_t       <= '0;
            c1_m       <= '0;
            c1_b       <= '0;
            win_valid  <= 1'b0;
            win_data   <= '0;
            win_x      <= '0;
            win_y      <= '0;
            frame_done <= 1'b0;
            cfg_err    <= 1'b0;
`ifdef WLB_WIN_COUNT_EN
            win_count  <= '0;
`endif
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (cfg_legal) begin
                            state    <= RUN;
                            w_reg    <= cfg_width;
                            h_reg    <= cfg_height;
                            col      <= '0;
                            row      <= '0;
                            pix_done <= 1'b0;
                            cfg_err  <= 1'b0;
`ifdef WLB_WIN_COUNT_EN
                            win_count <= '0;
`endif
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        // Each line starts with an empty column history.
                        if (col == '0) begin
                            c0_t <= '0;
                            c0_m <= '0;
                            c0_b <= '0;
                        end else begin
                            c0_t <= c1_t;
                            c0_m <= c1_m;
                            c0_b <= c1_b;
                        end
                        c1_t <= lb0_rd;
                        c1_m <= lb1_rd;
                        c1_b <= in_data;
                        if (last_col) begin
                            col <= '0;
                            row <= row + 16'd1;
                            if (row == h_reg - 16'd1) begin
                                pix_done <= 1'b1;
                            end
                        end else begin
                            col <= col + CW'(1);
                        end
                    end

                    if (load) begin
                        win_data  <= win_next;
                        win_x     <= 16'(col) - 16'd1;
                        win_y     <= row - 16'd1;
                        win_valid <= 1'b1;
                    end else if (handshake) begin
                        win_valid <= 1'b0;
                    end

`ifdef WLB_WIN_COUNT_EN
                    if (handshake) begin
                        win_count <= win_count + 16'd1;
                    end
`endif

                    // No loads can follow pix_done, so a draining handshake
                    // leaves win_valid low: finish on that same edge.
                    if (pix_done && (!win_valid || win_ready)) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_window_line_buffer.sv
module tb_window_line_buffer;

    localparam int DW = 32;
    localparam int WB = 9 * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [6:0]    cfg_width;
    logic [15:0]   cfg_height;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          win_valid;
    logic [WB-1:0] win_data;
    logic          win_ready;
    logic [15:0]   win_x;
    logic [15:0]   win_y;
    logic          busy;
    logic          frame_done;
    logic          cfg_err;
`ifdef WLB_WIN_COUNT_EN
    logic [15:0]   win_count;
`endif

    window_line_buffer #(.DATA_W(DW), .IMG_W_MAX(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .win_valid  (win_valid),
        .win_data   (win_data),
        .win_ready  (win_ready),
        .win_x      (win_x),
        .win_y      (win_y),
        .busy       (busy),
        .frame_done (frame_done),
        .cfg_err    (cfg_err)
`ifdef WLB_WIN_COUNT_EN
        ,
        .win_count  (win_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WB-1:0] data;
        logic [15:0]   x;
        logic [15:0]   y;
    } win_t;

    win_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   hs_count = 0;
    int   last_hs_cyc = -10;
    bit   frame_seen = 0;
    win_t first_win, last_win;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [WB-1:0] got, input logic [WB-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [WB-1:0] pack9(input int v[9]);
        logic [WB-1:0] r;
        r = '0;
        for (int k = 0; k < 9; k++) r[k*DW +: DW] = v[k];
        return r;
    endfunction

    // Compare process: every window handshake is checked against the model
    // queue; frame_done must follow the last handshake by exactly one cycle.
    always @(negedge clk) begin
        win_t e;
        #2;
        if (!rst && win_valid && win_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL extra_window: got window at (%0d,%0d) expected none", win_x, win_y);
            end else begin
                e = exp_q.pop_front();
                check("win_data", win_data, e.data);
                check("win_x", win_x, e.x);
                check("win_y", win_y, e.y);
            end
            if (hs_count == 0) begin
                first_win.data = win_data;
                first_win.x    = win_x;
                first_win.y    = win_y;
            end
            last_win.data = win_data;
            last_win.x    = win_x;
            last_win.y    = win_y;
            hs_count++;
            last_hs_cyc = cyc;
        end
        if (!rst && frame_done) begin
            frame_seen = 1;
            check("frame_done_latency", cyc, last_hs_cyc + 1);
        end
    end

    // Drives one frame of pixels base, base+1, ... in raster order.
    // stall: hold win_ready low for 5 cycles once the first window shows.
    task automatic run_frame(input int w, input int h, input int base, input bit stall, input int nwin);
        win_t e;
        int n, idx, stall_left;
        bit accepted, held_cap;
        logic [WB-1:0] held_d;
        logic [15:0]   held_x, held_y;
        exp_q.delete();
        for (int y = 1; y <= h - 2; y++) begin
            for (int x = 1; x <= w - 2; x++) begin
                e.data = '0;
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        e.data[(3*r+c)*DW +: DW] = base + (y - 1 + r) * w + (x - 1 + c);
                e.x = 16'(x);
                e.y = 16'(y);
                exp_q.push_back(e);
            end
        end
        hs_count   = 0;
        frame_seen = 0;
        n          = w * h;
        idx        = 0;
        stall_left = stall ? 5 : 0;
        held_cap   = 0;
        @(negedge clk);
        start      = 1'b1;
        cfg_width  = 7'(w);
        cfg_height = 16'(h);
        @(negedge clk);
        start = 1'b0;
        #1;
        check("start_to_in_ready", in_ready, 1'b1);
        for (int c = 0; c < 500 && !frame_seen; c++) begin
            in_valid  = 1'b1;
            in_data   = (idx < n) ? DW'(base + idx) : 32'hdead_beef;
            win_ready = !(stall_left > 0 && win_valid);
            #1;
            if (!win_ready) begin
                check("stall_in_ready", in_ready, 1'b0);
                if (!held_cap) begin
                    held_d = win_data;
                    held_x = win_x;
                    held_y = win_y;
                    held_cap = 1;
                end else begin
                    check("stall_hold", {win_data, win_x, win_y}, {held_d, held_x, held_y});
                end
                stall_left--;
            end
            if (idx >= n) check("no_extra_accept", in_ready, 1'b0);
            accepted = in_valid && in_ready;
            @(negedge clk);
            if (accepted) idx++;
        end
        in_valid = 1'b0;
        if (!frame_seen) begin
            checks++;
            failures++;
            $display("FAIL frame_timeout: got no frame_done expected frame_done within budget");
        end
        check("window_count", hs_count, nwin);
        check("model_drained", exp_q.size(), 0);
        check("accepted_pixels", idx, n);
        #1;
        check("busy_after_done", busy, 1'b0);
`ifdef WLB_WIN_COUNT_EN
        check("win_count", win_count, nwin);
`endif
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; cfg_width = '0; cfg_height = '0;
        in_valid = 1'b0; in_data = '0; win_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_win_valid", win_valid, 1'b0);
        check("rst_win_data", win_data, '0);
        check("rst_win_xy", {win_x, win_y}, 32'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_cfg_err", cfg_err, 1'b0);

        // 4x4, pixels 1..16, no backpressure
        run_frame(4, 4, 1, 0, 4);
        check("t1_first", {first_win.data, first_win.x, first_win.y},
              {pack9('{1, 2, 3, 5, 6, 7, 9, 10, 11}), 16'd1, 16'd1});
        check("t1_last", {last_win.data, last_win.x, last_win.y},
              {pack9('{6, 7, 8, 10, 11, 12, 14, 15, 16}), 16'd2, 16'd2});

        // same frame with a 5-cycle stall on the first window
        run_frame(4, 4, 1, 1, 4);
        check("t2_first", {first_win.data, first_win.x, first_win.y},
              {pack9('{1, 2, 3, 5, 6, 7, 9, 10, 11}), 16'd1, 16'd1});
        check("t2_last", {last_win.data, last_win.x, last_win.y},
              {pack9('{6, 7, 8, 10, 11, 12, 14, 15, 16}), 16'd2, 16'd2});

        // illegal configurations: width 2, width 65, height 2
        @(negedge clk);
        start = 1'b1; cfg_width = 7'd2; cfg_height = 16'd4;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; win_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("cfg_err_in_ready", in_ready, 1'b0);
            @(negedge clk);
        end
        #1;
        check("cfg_err_w2", cfg_err, 1'b1);
        check("cfg_err_busy", busy, 1'b0);
        @(negedge clk);
        start = 1'b1; cfg_width = 7'd65; cfg_height = 16'd4;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("cfg_err_w65", cfg_err, 1'b1);
        check("cfg_err_w65_busy", busy, 1'b0);
        @(negedge clk);
        start = 1'b1; cfg_width = 7'd4; cfg_height = 16'd2;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("cfg_err_h2", cfg_err, 1'b1);

        // legal start clears cfg_err; then reset with a window pending
        @(negedge clk);
        start = 1'b1; cfg_width = 7'd4; cfg_height = 16'd4;
        @(negedge clk);
        start = 1'b0; win_ready = 1'b0;
        #1;
        check("cfg_err_cleared", cfg_err, 1'b0);
        exp_q.delete();
        for (int i = 0; i < 40 && !win_valid; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = DW'(1000 + i);
            #1;
        end
        check("pending_before_rst", win_valid, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_drops_window", win_valid, 1'b0);
        check("rst_busy_mid", busy, 1'b0);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 3x3 frame -5..3 after the mid-frame reset
        run_frame(3, 3, -5, 0, 1);
        check("t4_window", {first_win.data, first_win.x, first_win.y},
              {pack9('{-5, -4, -3, -2, -1, 0, 1, 2, 3}), 16'd1, 16'd1});

        // back-to-back 5x3 then 3x5
        run_frame(5, 3, 100, 0, 3);
        check("t5a_first", {first_win.data, first_win.x, first_win.y},
              {pack9('{100, 101, 102, 105, 106, 107, 110, 111, 112}), 16'd1, 16'd1});
        run_frame(3, 5, 200, 0, 3);
        check("t5b_last", {last_win.data, last_win.x, last_win.y},
              {pack9('{206, 207, 208, 209, 210, 211, 212, 213, 214}), 16'd1, 16'd3});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
